// File: rtl/sq_wave_pkg.sv
// Shared types, widths and first-phase helpers for the multi-channel square-wave generator.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sq_wave_pkg;

   // Default geometry; the top exposes these as parameters for the port widths
   localparam int SQ_CH       = 4;
   localparam int SQ_N        = 8;
   localparam int SQ_BW       = 8;
   localparam int SQ_PRESCALE = 10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } sq_state_t;

   // One channel's programming: high ticks, low ticks, periods per burst (0 = run forever)
   typedef struct packed {
      logic [SQ_N-1:0]  m;
      logic [SQ_N-1:0]  n;
      logic [SQ_BW-1:0] burst;
   } ch_cfg_t;

   // Phase a period starts in: HIGH when m is non-zero, otherwise LOW, IDLE when both are zero
   function automatic sq_state_t first_state(input ch_cfg_t c);
      if (c.m != '0)      return HIGH;
      else if (c.n != '0) return LOW;
      else                return IDLE;
   endfunction

   // Tick counter load for the first phase; only ever loads x-1 for a non-zero x, so no wrap
   function automatic logic [SQ_N-1:0] first_cnt(input ch_cfg_t c);
      if (c.m != '0)      return c.m - SQ_N'(1);
      else if (c.n != '0) return c.n - SQ_N'(1);
      else                return '0;
   endfunction

endpackage

// File: rtl/sq_wave_channel.sv
// One square-wave channel: HIGH/LOW FSM, tick counter, burst counter, double-buffered config.
// Latency: q/busy/period_done are registered, one clk after the tick that changes state.
// Backpressure: pend_vld high while a shadow config waits for the period end; the top stalls writes to it.
module sq_wave_channel
   import sq_wave_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    en,
   input  logic    sync,
   input  logic    tick,
   input  logic    wr_vld,
   input  ch_cfg_t wr_cfg,
   output logic    q,
   output logic    period_done,
   output logic    busy,
   output logic    pend_vld
);

   sq_state_t        state, state_nxt;
   logic [SQ_N-1:0]  cnt, cnt_nxt;
   logic [SQ_BW-1:0] rem, rem_nxt;
   ch_cfg_t          act_cfg, act_nxt;
   ch_cfg_t          pend_cfg, pend_cfg_nxt;
   ch_cfg_t          eff_cfg;
   logic             pend_nxt;
   logic             armed, armed_nxt;
   logic             done_nxt;
   logic             period_end;

   // Config that the next period start will use: a waiting shadow copy wins over the active one
   assign eff_cfg = pend_vld ? pend_cfg : act_cfg;

   // Period end detection: last tick of LOW, or last tick of HIGH when there is no LOW phase
   always_comb begin
      period_end = 1'b0;
      if (en && !sync && tick && (cnt == '0)) begin
         if (state == LOW)                         period_end = 1'b1;
         else if (state == HIGH && act_cfg.n == '0) period_end = 1'b1;
      end
   end

   // Next-state logic; priority is sync > en-drop > tick, and writes always land in the shadow
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      rem_nxt      = rem;
      act_nxt      = act_cfg;
      pend_cfg_nxt = pend_cfg;
      pend_nxt     = pend_vld;
      armed_nxt    = armed;
      done_nxt     = 1'b0;

      if (sync && en) begin
         // Park in IDLE with the latest config; the cleared prescaler launches every
         // enabled channel together on the first tick afterwards
         state_nxt = IDLE;
         cnt_nxt   = '0;
         act_nxt   = eff_cfg;
         pend_nxt  = 1'b0;
         armed_nxt = 1'b1;
      end else if (!en) begin
         // Drop straight to IDLE without a period_done; a waiting shadow survives until IDLE
         state_nxt = IDLE;
         cnt_nxt   = '0;
         armed_nxt = 1'b1;
         if (state == IDLE) begin
            act_nxt  = eff_cfg;
            pend_nxt = 1'b0;
         end
      end else begin
         case (state)
            IDLE: begin
               // Idle channels take a new config immediately; a fresh config re-arms after a burst
               act_nxt  = eff_cfg;
               pend_nxt = 1'b0;
               if (pend_vld) armed_nxt = 1'b1;
               if (tick && (armed || pend_vld)) begin
                  state_nxt = first_state(eff_cfg);
                  cnt_nxt   = first_cnt(eff_cfg);
                  rem_nxt   = eff_cfg.burst;
               end
            end
            HIGH: begin
               if (tick) begin
                  if (cnt != '0) begin
                     cnt_nxt = cnt - SQ_N'(1);
                  end else if (act_cfg.n != '0) begin
                     state_nxt = LOW;
                     cnt_nxt   = act_cfg.n - SQ_N'(1);
                  end
               end
            end
            LOW: begin
               if (tick && cnt != '0) cnt_nxt = cnt - SQ_N'(1);
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase

         if (period_end) begin
            done_nxt = 1'b1;
            act_nxt  = eff_cfg;
            pend_nxt = 1'b0;
            if (rem != '0) begin
               // Burst: count down, and stay idle once the last period is out
               rem_nxt = rem - SQ_BW'(1);
               if (rem == SQ_BW'(1)) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
                  armed_nxt = 1'b0;
               end else begin
                  state_nxt = first_state(eff_cfg);
                  cnt_nxt   = first_cnt(eff_cfg);
               end
            end else begin
               // Continuous: restart at once, picking up a burst length if the new config has one
               rem_nxt   = eff_cfg.burst;
               state_nxt = first_state(eff_cfg);
               cnt_nxt   = first_cnt(eff_cfg);
            end
         end
      end

      if (wr_vld) begin
         pend_cfg_nxt = wr_cfg;
         pend_nxt     = 1'b1;
      end
   end

   // State and registered outputs; q/busy come from the next state so they match the state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rem         <= '0;
         act_cfg     <= '0;
         pend_cfg    <= '0;
         pend_vld    <= 1'b0;
         armed       <= 1'b1;
         q           <= 1'b0;
         busy        <= 1'b0;
         period_done <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         rem         <= rem_nxt;
         act_cfg     <= act_nxt;
         pend_cfg    <= pend_cfg_nxt;
         pend_vld    <= pend_nxt;
         armed       <= armed_nxt;
         q           <= (state_nxt == HIGH);
         busy        <= (state_nxt != IDLE);
         period_done <= done_nxt;
      end
   end

endmodule

// File: rtl/multi_square_wave_gen.sv
// CH-channel programmable square-wave generator with shared prescaler and global sync.
// Latency: outputs registered; a synced channel's first edge appears PRESCALE clks after sync.
// Backpressure: cfg_ready drops while the addressed channel still holds an unapplied shadow config.
module multi_square_wave_gen
   import sq_wave_pkg::*;
#(
   parameter int  CH       = SQ_CH,
   parameter int  N        = SQ_N,
   parameter int  BW       = SQ_BW,
   parameter int  PRESCALE = SQ_PRESCALE,
   localparam int CW       = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] en,
   input  logic          sync,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [CW-1:0] cfg_ch,
   input  logic [N-1:0]  cfg_m,
   input  logic [N-1:0]  cfg_n,
   input  logic [BW-1:0] cfg_burst,
   output logic [CH-1:0] q,
   output logic [CH-1:0] period_done,
   output logic [CH-1:0] busy
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [CH-1:0] pend_vld;
   logic [CH-1:0] wr_vld;
   ch_cfg_t       wr_cfg;

   assign tick   = (pre_cnt == PW'(PRESCALE - 1));
   assign wr_cfg = '{m: cfg_m, n: cfg_n, burst: cfg_burst};

   // Shared prescaler: 0..PRESCALE-1, cleared by sync so all channels see the same tick phase
   always_ff @(posedge clk) begin
      if (reset || sync) pre_cnt <= '0;
      else if (tick)     pre_cnt <= '0;
      else               pre_cnt <= pre_cnt + PW'(1);
   end

   // Ready mux: out-of-range channel numbers are always accepted and simply dropped
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < CH; i++) begin
         if (cfg_ch == CW'(i)) cfg_ready = !pend_vld[i];
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      assign wr_vld[i] = cfg_valid && cfg_ready && (cfg_ch == CW'(i));

      sq_wave_channel u_ch (
         .clk         (clk),
         .reset       (reset),
         .en          (en[i]),
         .sync        (sync),
         .tick        (tick),
         .wr_vld      (wr_vld[i]),
         .wr_cfg      (wr_cfg),
         .q           (q[i]),
         .period_done (period_done[i]),
         .busy        (busy[i]),
         .pend_vld    (pend_vld[i])
      );
   end

endmodule
